// File: rtl/rps_match_engine.sv
// Best-of-N stone-paper-scissors match controller with two-player and CPU (LFSR) modes.
// Tracks per-player scores and declares a match winner once a player reaches WIN_TARGET.
module rps_match_engine #(
  parameter int unsigned SCORE_W    = 4,
  parameter int unsigned WIN_TARGET = 3,
  parameter int unsigned LFSR_W     = 8,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(8'hA5)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic               new_match,
  input  logic [1:0]         p1_move,
  input  logic [1:0]         p2_move,
  output logic [1:0]         round_winner,
  output logic               round_done,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               match_over,
  output logic [1:0]         match_winner,
  output logic [1:0]         cpu_move,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    EVAL      = 3'd1,
    WAIT_REL  = 3'd2,
    MATCH_END = 3'd3
  } state_t;

  localparam logic [1:0] MV_ROCK     = 2'b00;
  localparam logic [1:0] MV_PAPER    = 2'b01;
  localparam logic [1:0] MV_SCISSORS = 2'b10;
  localparam logic [1:0] MV_ILLEGAL  = 2'b11;

  localparam logic [1:0] RES_TIE     = 2'b00;
  localparam logic [1:0] RES_P1      = 2'b01;
  localparam logic [1:0] RES_P2      = 2'b10;
  localparam logic [1:0] RES_INVALID = 2'b11;

  localparam logic [SCORE_W-1:0] TARGET = SCORE_W'(WIN_TARGET);

  // Feedback taps: x^8+x^6+x^5+x^4+1 for the 8-bit case, a two-tap fallback otherwise.
  localparam logic [LFSR_W-1:0] TAPS = (LFSR_W == 8) ? LFSR_W'(8'hB8)
                                                     : (LFSR_W'(3) << (LFSR_W - 2));

  state_t              state_q;
  logic [LFSR_W-1:0]   lfsr;
  logic [1:0]          p1_lat;
  logic [1:0]          p2_lat;
  logic [1:0]          cpu_pick_c;
  logic [1:0]          result_c;
  logic [SCORE_W-1:0]  p1_inc_c;
  logic [SCORE_W-1:0]  p2_inc_c;

  assign state = state_q;

  function automatic logic [1:0] judge(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] r;
    r = RES_P2;
    if (a == b) begin
      r = RES_TIE;
    end else begin
      case ({a, b})
        {MV_ROCK, MV_SCISSORS},
        {MV_PAPER, MV_ROCK},
        {MV_SCISSORS, MV_PAPER}: r = RES_P1;
        default:                 r = RES_P2;
      endcase
    end
    return r;
  endfunction

  // CPU move from the low LFSR bits; the illegal code folds onto rock.
  assign cpu_pick_c = (lfsr[1:0] == MV_ILLEGAL) ? MV_ROCK : lfsr[1:0];
  assign result_c   = (p1_lat == MV_ILLEGAL || p2_lat == MV_ILLEGAL) ? RES_INVALID
                                                                     : judge(p1_lat, p2_lat);
  assign p1_inc_c   = p1_score + SCORE_W'(1);
  assign p2_inc_c   = p2_score + SCORE_W'(1);

  // Free-running opponent source, independent of the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};
    end
  end

  // Match FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      p1_lat       <= 2'b00;
      p2_lat       <= 2'b00;
      round_winner <= RES_TIE;
      round_done   <= 1'b0;
      p1_score     <= '0;
      p2_score     <= '0;
      match_over   <= 1'b0;
      match_winner <= 2'b00;
      cpu_move     <= 2'b00;
    end else begin
      round_done <= 1'b0;
      if (new_match) begin
        state_q      <= IDLE;
        round_winner <= RES_TIE;
        p1_score     <= '0;
        p2_score     <= '0;
        match_over   <= 1'b0;
        match_winner <= 2'b00;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              p1_lat  <= p1_move;
              p2_lat  <= mode ? cpu_pick_c : p2_move;
              state_q <= EVAL;
            end
          end
          EVAL: begin
            round_done   <= 1'b1;
            cpu_move     <= p2_lat;
            round_winner <= result_c;
            state_q      <= WAIT_REL;
            if (result_c == RES_P1) begin
              p1_score <= p1_inc_c;
              if (p1_inc_c == TARGET) begin
                state_q      <= MATCH_END;
                match_over   <= 1'b1;
                match_winner <= RES_P1;
              end
            end else if (result_c == RES_P2) begin
              p2_score <= p2_inc_c;
              if (p2_inc_c == TARGET) begin
                state_q      <= MATCH_END;
                match_over   <= 1'b1;
                match_winner <= RES_P2;
              end
            end
          end
          WAIT_REL: begin
            if (!start) begin
              state_q <= IDLE;
            end
          end
          MATCH_END: begin
            state_q <= MATCH_END;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rps_match_engine.sv
// Directed bench for rps_match_engine: a round-level behavioural model is checked every cycle,
// with hand-computed literal expectations pinning the key scenarios.
module tb_rps_match_engine;

  localparam int unsigned SCORE_W    = 4;
  localparam int unsigned WIN_TARGET = 3;

  logic               clk;
  logic               reset;
  logic               start;
  logic               mode;
  logic               new_match;
  logic [1:0]         p1_move;
  logic [1:0]         p2_move;
  logic [1:0]         round_winner;
  logic               round_done;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic               match_over;
  logic [1:0]         match_winner;
  logic [1:0]         cpu_move;
  logic [2:0]         state;

  int n_checks = 0;
  int n_errors = 0;
  int rd_count = 0;

  rps_match_engine #(
    .SCORE_W   (SCORE_W),
    .WIN_TARGET(WIN_TARGET),
    .LFSR_W    (8),
    .LFSR_SEED (8'hA5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .new_match   (new_match),
    .p1_move     (p1_move),
    .p2_move     (p2_move),
    .round_winner(round_winner),
    .round_done  (round_done),
    .p1_score    (p1_score),
    .p2_score    (p2_score),
    .match_over  (match_over),
    .match_winner(match_winner),
    .cpu_move    (cpu_move),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases use the spec's numbering: 0 idle, 1 evaluating, 2 waiting for release, 3 match over.
  int m_phase, m_rw, m_rd, m_p1, m_p2, m_mo, m_mw, m_cpu, m_lfsr, m_l1, m_l2;

  function automatic int lfsr_step(input int v);
    int taps[4] = '{7, 5, 4, 3};
    int fb = 0;
    foreach (taps[i]) fb = fb ^ ((v >> taps[i]) & 1);
    return ((v * 2) % 256) + fb;
  endfunction

  // Rock 0, paper 1, scissors 2: the mover one step "ahead" mod 3 wins.
  function automatic int outcome(input int a, input int b);
    if (a == 3 || b == 3) return 3;
    if (a == b) return 0;
    return (((a - b + 3) % 3) == 1) ? 1 : 2;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_rw = 0; m_rd = 0; m_p1 = 0; m_p2 = 0;
      m_mo = 0; m_mw = 0; m_cpu = 0; m_lfsr = 'hA5; m_l1 = 0; m_l2 = 0;
    end else begin
      int cur_lfsr;
      int w;
      cur_lfsr = m_lfsr;
      m_lfsr = lfsr_step(m_lfsr);
      m_rd = 0;
      if (new_match) begin
        m_phase = 0; m_rw = 0; m_p1 = 0; m_p2 = 0; m_mo = 0; m_mw = 0;
      end else if (m_phase == 0) begin
        if (start) begin
          m_l1 = int'(p1_move);
          m_l2 = mode ? ((cur_lfsr % 4) == 3 ? 0 : cur_lfsr % 4) : int'(p2_move);
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        w = outcome(m_l1, m_l2);
        m_rd = 1; m_cpu = m_l2; m_rw = w; m_phase = 2;
        if (w == 1) m_p1++;
        if (w == 2) m_p2++;
        if ((w == 1 && m_p1 == WIN_TARGET) || (w == 2 && m_p2 == WIN_TARGET)) begin
          m_phase = 3; m_mo = 1; m_mw = w;
        end
      end else if (m_phase == 2) begin
        if (!start) m_phase = 0;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (round_done === 1'b1) rd_count++;
    check("state",        int'(state),        m_phase);
    check("round_winner", int'(round_winner), m_rw);
    check("round_done",   int'(round_done),   m_rd);
    check("p1_score",     int'(p1_score),     m_p1);
    check("p2_score",     int'(p2_score),     m_p2);
    check("match_over",   int'(match_over),   m_mo);
    check("match_winner", int'(match_winner), m_mw);
    check("cpu_move",     int'(cpu_move),     m_cpu);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a round and advance to the cycle where its result is visible.
  task automatic launch(input logic [1:0] a, input logic [1:0] b, input logic md);
    p1_move = a; p2_move = b; mode = md; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rd_before;
    reset = 1'b1; start = 1'b0; mode = 1'b0; new_match = 1'b0;
    p1_move = 2'b00; p2_move = 2'b00;
    repeat (3) tick();
    reset = 1'b0;
    check("reset_state", int'(state), 0);
    check("reset_scores", int'(p1_score) + int'(p2_score), 0);
    check("reset_round_done", int'(round_done), 0);

    // 1: rock vs rock is a tie, result one cycle after the start edge
    launch(2'b00, 2'b00, 1'b0);
    check("t1_round_winner", int'(round_winner), 0);
    check("t1_round_done", int'(round_done), 1);
    check("t1_scores", int'(p1_score) * 16 + int'(p2_score), 0);
    tick();

    // 2: rock beats scissors three times -> P1 takes the match
    for (int r = 1; r <= 3; r++) begin
      launch(2'b00, 2'b10, 1'b0);
      check("t2_round_winner", int'(round_winner), 1);
      check("t2_p1_score", int'(p1_score), r);
      tick();
    end
    check("t2_match_over", int'(match_over), 1);
    check("t2_match_winner", int'(match_winner), 1);
    check("t2_state", int'(state), 3);

    // 3: start ignored in MATCH_END; new_match wins over a concurrent start
    rd_before = rd_count;
    start = 1'b1;
    repeat (2) tick();
    check("t3_frozen_p1", int'(p1_score), 3);
    check("t3_frozen_state", int'(state), 3);
    new_match = 1'b1;
    tick();
    new_match = 1'b0; start = 1'b0;
    check("t3_cleared_scores", int'(p1_score) + int'(p2_score), 0);
    check("t3_cleared_state", int'(state), 0);
    check("t3_cleared_over", int'(match_over), 0);
    repeat (2) tick();
    check("t3_no_round", rd_count - rd_before, 0);

    // 4: illegal P1 move; start held for five cycles plays exactly one round
    rd_before = rd_count;
    p1_move = 2'b11; p2_move = 2'b01; start = 1'b1;
    tick();
    tick();
    check("t4_round_winner", int'(round_winner), 3);
    repeat (3) tick();
    start = 1'b0;
    repeat (2) tick();
    check("t4_one_round", rd_count - rd_before, 1);
    check("t4_scores", int'(p1_score) + int'(p2_score), 0);

    // 5: CPU opponent; p2_move is deliberately illegal to show it is ignored
    for (int r = 0; r < 4; r++) begin
      launch(2'b01, 2'b11, 1'b1);
      check("t5_cpu_legal", (cpu_move == 2'b11) ? 1 : 0, 0);
      tick();
    end

    // 6: reset during EVAL clears everything asynchronously
    new_match = 1'b1;
    tick();
    new_match = 1'b0;
    launch(2'b00, 2'b10, 1'b0);
    tick();
    rd_before = rd_count;
    p1_move = 2'b01; p2_move = 2'b00; mode = 1'b0; start = 1'b1;
    tick();
    check("t6_in_eval", int'(state), 1);
    start = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("t6_async_state", int'(state), 0);
    check("t6_async_p1", int'(p1_score), 0);
    check("t6_async_outputs",
          int'(round_winner) + int'(round_done) + int'(match_over) + int'(match_winner) + int'(cpu_move), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) tick();
    check("t6_no_round_done", rd_count - rd_before, 0);
    check("t6_idle", int'(state), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
